// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide sequencer for the EX stage.
// One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract
// for divide. Operands are reduced to magnitudes on acceptance and the sign is
// reapplied on the final iteration, so the datapath itself is purely unsigned.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;       // final result must be negated
  logic [2*XLEN-1:0]   mcand_q, mcand_d;   // |A| shifted left one place per step
  logic [XLEN-1:0]     mplier_q, mplier_d; // |B| shifted right one place per step
  logic [2*XLEN-1:0]   acc_q, acc_d;       // product accumulator
  logic [XLEN-1:0]     dvd_q, dvd_d;       // dividend bits out at MSB, quotient bits in at LSB
  logic [XLEN-1:0]     rem_q, rem_d;       // partial remainder (always < divisor)
  logic [XLEN-1:0]     dvsr_q, dvsr_d;
  logic [XLEN-1:0]     result_q, result_d;

  function automatic logic [XLEN-1:0] cond_neg(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic n, input logic [2*XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Operand decode at acceptance: signedness, magnitudes and early-out cases.
  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  logic            div_zero, div_ovf, special;

  assign a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                    (funct3 == F_DIV)  || (funct3 == F_REM);
  assign b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
  assign sa       = a_signed & rs1_data[XLEN-1];
  assign sb       = b_signed & rs2_data[XLEN-1];
  assign a_mag    = cond_neg(sa, rs1_data);
  assign b_mag    = cond_neg(sb, rs2_data);
  assign div_zero = (rs2_data == '0);
  assign div_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                    (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign special  = funct3[2] && (div_zero || div_ovf);
  // funct3[1] separates remainder from quotient among the divide ops.
  assign spec_res = div_zero ? (funct3[1] ? rs1_data : '1)
                             : (funct3[1] ? '0 : rs1_data);

  // One iteration of each datapath; the remainder is widened by one bit after
  // the shift so the compare against the divisor cannot overflow.
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN:0]     rem_sub;
  logic [2*XLEN-1:0] acc_nx;
  logic [XLEN-1:0]   dvd_nx, rem_nx;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_res, div_res;

  assign rem_sh  = {rem_q, dvd_q[XLEN-1]};
  assign rem_ge  = (rem_sh >= {1'b0, dvsr_q});
  assign rem_sub = rem_sh - {1'b0, dvsr_q};
  assign rem_nx  = rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign dvd_nx  = {dvd_q[XLEN-2:0], rem_ge};
  assign acc_nx  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_s  = cond_neg2(neg_q, acc_nx);
  assign mul_res = (op_q == F_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  assign div_res = op_q[1] ? cond_neg(neg_q, rem_nx) : cond_neg(neg_q, dvd_nx);

  // Next-state, datapath loads and result capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (special) begin
            state_d  = S_DONE;
            result_d = spec_res;
          end else begin
            state_d  = S_CALC;
            cnt_d    = '0;
            op_d     = funct3;
            // Remainder follows the dividend sign; everything else is sa^sb.
            neg_d    = (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
            mcand_d  = {{XLEN{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            dvd_d    = a_mag;
            rem_d    = '0;
            dvsr_d   = b_mag;
          end
        end
      end
      S_CALC: begin
        acc_d    = acc_nx;
        mcand_d  = {mcand_q[2*XLEN-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[XLEN-1:1]};
        dvd_d    = dvd_nx;
        rem_d    = rem_nx;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = op_q[2] ? div_res : mul_res;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything: back to idle, result untouched.
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign stall  = (start && (state_q == S_IDLE) && !flush) || (state_q == S_CALC);
  assign result = result_q;

endmodule
